// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM and owner encodings for mem_arb
package mem_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} own_t;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch port, data port and memory-macro port of mem_arb
//   i_*   : fetch requester (req/addr in, rdata/done out)
//   d_*   : load/store requester (req/we/addr/wdata in, rdata/done out)
//   m_*   : single-ported memory macro (en/we/addr/wdata out, rdata in)
//   busy  : arbiter not idle
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_done, d_rdata, d_done, m_en, m_we, m_addr, m_wdata, busy
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_done, d_rdata, d_done, m_en, m_we, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_arb_arb_pick.sv
// arb_pick: grant selection; data wins unless fetch has hit its starvation limit
//   i_req, d_req : pending requests
//   starved      : fetch has lost STARVE_MAX consecutive contentions
//   gnt_i, gnt_d : one-hot (or zero) grant
module arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starved,
    output logic gnt_i,
    output logic gnt_d
);
    assign gnt_d = d_req & ~(i_req & starved);
    assign gnt_i = i_req & ~gnt_d;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one single-ported synchronous memory between fetch and data ports
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   bus           : mem_arb_if slave view (fetch, data and memory ports, busy)
module mem_arb import mem_arb_pkg::*; #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic      clock,
    input logic      resetn,
    mem_arb_if.slave bus
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    state_t        state, state_nxt;
    own_t          own;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] i_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          gnt_i, gnt_d;
    logic          grant, last;
    arb_pick u_pick (
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .starved (starve == SW'(STARVE_MAX)),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );
    assign grant = state == ST_IDLE && (gnt_i || gnt_d);
    assign last  = cnt == CW'(MEM_LAT - 1);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = state == ST_IDLE   ? (grant ? ST_ACCESS : ST_IDLE)
                  : state == ST_ACCESS ? (last ? ST_DONE : ST_ACCESS)
                  :                      ST_IDLE;
    end
    // Starve only advances when fetch actually lost a contention.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            own       <= OWN_I;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
            cnt       <= '0;
            starve    <= '0;
        end else begin
            cnt <= state == ST_ACCESS && !last ? cnt + 1'b1 : '0;
            if (grant) begin
                own     <= gnt_d ? OWN_D : OWN_I;
                addr_r  <= gnt_d ? bus.d_addr : bus.i_addr;
                we_r    <= gnt_d & bus.d_we;
                wdata_r <= gnt_d ? bus.d_wdata : '0;
                starve  <= gnt_i ? '0 : bus.i_req ? starve + 1'b1 : starve;
            end
            if (state == ST_ACCESS && last && own == OWN_I) i_rdata_r <= bus.m_rdata;
            if (state == ST_ACCESS && last && own == OWN_D && !we_r) d_rdata_r <= bus.m_rdata;
        end
    end
    assign bus.m_en    = state == ST_ACCESS && cnt == '0;
    assign bus.m_we    = bus.m_en & we_r;
    assign bus.m_addr  = addr_r;
    assign bus.m_wdata = wdata_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.i_done  = state == ST_DONE && own == OWN_I;
    assign bus.d_done  = state == ST_DONE && own == OWN_D;
    assign bus.busy    = state != ST_IDLE;
endmodule
